// File: rtl/interp_pkg.sv
// Shared types and helpers for the pilot-gap interpolation step generator.
// Covers the FSM state encoding, accumulator sizing, rounding modes and output clamping.
package interp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam int RND_FLOOR   = 0;
    localparam int RND_HALF_UP = 1;

    localparam int DW_DEFAULT    = 16;
    localparam int SHIFT_DEFAULT = 3;
    localparam int AW_DEFAULT    = DW_DEFAULT + SHIFT_DEFAULT + 1;

    // Accumulator width: one pilot, plus N steps of at most one pilot span each.
    function automatic int calc_aw(input int dw, input int shift);
        return dw + shift + 1;
    endfunction

    // Clamp a signed value into the range of a signed 'width'-bit number.
    function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/interp_lane.sv
// One I or Q lane: latches the pilot pair, derives the per-sample step and
// walks the accumulator, presenting a saturated view of it on data.
module interp_lane
    import interp_pkg::*;
#(
    parameter int DW    = 16,
    parameter int OW    = 16,
    parameter int SHIFT = 3,
    parameter int RND   = RND_FLOOR,
    parameter int AW    = calc_aw(DW, SHIFT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          calc,
    input  logic          advance,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [OW-1:0] data
);

    localparam int RND_ADD = (RND == RND_HALF_UP) ? (1 << (SHIFT - 1)) : 0;
    localparam logic signed [AW-1:0] OUT_HI = AW'(sat(64'sh7FFF_FFFF_FFFF_FFFF, OW));
    localparam logic signed [AW-1:0] OUT_LO = AW'(sat(-64'sh7FFF_FFFF_FFFF_FFFF - 64'sd1, OW));

    logic signed [AW-1:0]   acc_reg;
    logic signed [DW:0]     diff_reg;
    logic signed [AW-1:0]   step_reg;
    logic signed [DW+1:0]   diff_rnd;
    logic signed [DW+1:0]   step_shift;
    logic signed [DW-1:0]   a_s;
    logic signed [DW-1:0]   b_s;

    assign a_s = a;
    assign b_s = b;

    // Two guard bits so the rounding offset can never overflow the difference.
    assign diff_rnd   = (DW+2)'(diff_reg) + (DW+2)'(RND_ADD);
    assign step_shift = diff_rnd >>> SHIFT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg  <= '0;
            diff_reg <= '0;
            step_reg <= '0;
        end else begin
            if (load) begin
                acc_reg  <= AW'(a_s);
                diff_reg <= (DW+1)'(b_s) - (DW+1)'(a_s);
            end else if (advance) begin
                acc_reg  <= acc_reg + step_reg;
            end
            if (calc) begin
                step_reg <= AW'(step_shift);
            end
        end
    end

    // Clamp only the presented sample; the accumulator keeps full precision.
    always_comb begin
        data = acc_reg[OW-1:0];
        if (acc_reg > OUT_HI) begin
            data = OUT_HI[OW-1:0];
        end else if (acc_reg < OUT_LO) begin
            data = OUT_LO[OW-1:0];
        end
    end

endmodule

// File: rtl/interp_step_gen.sv
// Interpolates 2^SHIFT samples between two consecutive pilot estimates on NCH
// parallel lanes; the FSM, sample counter and both handshakes live here.
module interp_step_gen
    import interp_pkg::*;
#(
    parameter int DW    = 16,
    parameter int OW    = 16,
    parameter int SHIFT = 3,
    parameter int NCH   = 2,
    parameter int RND   = RND_FLOOR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*DW-1:0] pilot_a,
    input  logic [NCH*DW-1:0] pilot_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH*OW-1:0] out_data,
    output logic [SHIFT-1:0]  out_idx,
    output logic              out_last,
    output logic              busy
);

    localparam int AW = calc_aw(DW, SHIFT);
    localparam logic [SHIFT-1:0] K_LAST = '1;

    state_t           state_reg;
    logic [SHIFT-1:0] k_reg;
    logic [SHIFT-1:0] k_inc;
    logic             out_valid_reg;
    logic             out_last_reg;
    logic             busy_reg;
    logic             lane_load;
    logic             lane_calc;
    logic             lane_advance;

    assign k_inc        = k_reg + 1'b1;
    assign lane_load    = (state_reg == IDLE) && in_valid;
    assign lane_calc    = (state_reg == CALC);
    assign lane_advance = (state_reg == EMIT) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            k_reg         <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= CALC;
                        busy_reg  <= 1'b1;
                    end
                end
                CALC: begin
                    state_reg     <= EMIT;
                    k_reg         <= '0;
                    out_valid_reg <= 1'b1;
                    out_last_reg  <= 1'b0;
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last_reg) begin
                            state_reg     <= IDLE;
                            k_reg         <= '0;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            busy_reg      <= 1'b0;
                        end else begin
                            k_reg        <= k_inc;
                            out_last_reg <= (k_inc == K_LAST);
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    k_reg         <= '0;
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    // Gated by rst so the source sees no ready while the block is held in reset.
    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign out_idx   = k_reg;
    assign busy      = busy_reg;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
            interp_lane #(
                .DW    (DW),
                .OW    (OW),
                .SHIFT (SHIFT),
                .RND   (RND),
                .AW    (AW)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .load    (lane_load),
                .calc    (lane_calc),
                .advance (lane_advance),
                .a       (pilot_a[gi*DW +: DW]),
                .b       (pilot_b[gi*DW +: DW]),
                .data    (out_data[gi*OW +: OW])
            );
        end
    endgenerate

endmodule

// File: tb/tb_interp_step_gen.sv
// Directed bench: three configurations (floor, half-up, 12-bit output) share
// one stimulus stream; per-sample expectations come from hand-computed steps.
module tb_interp_step_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] pilot_a = '0;
    logic [31:0] pilot_b = '0;

    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic [31:0] out_data0, out_data1;
    logic [23:0] out_data2;
    logic [2:0]  out_idx0, out_idx1, out_idx2;
    logic        out_last0, out_last1, out_last2;
    logic        busy0, busy1, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    interp_step_gen #(.DW(16), .OW(16), .SHIFT(3), .NCH(2), .RND(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .pilot_a(pilot_a), .pilot_b(pilot_b), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_idx(out_idx0),
        .out_last(out_last0), .busy(busy0));

    interp_step_gen #(.DW(16), .OW(16), .SHIFT(3), .NCH(2), .RND(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .pilot_a(pilot_a), .pilot_b(pilot_b), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .out_idx(out_idx1),
        .out_last(out_last1), .busy(busy1));

    interp_step_gen #(.DW(16), .OW(12), .SHIFT(3), .NCH(2), .RND(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .pilot_a(pilot_a), .pilot_b(pilot_b), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .out_idx(out_idx2),
        .out_last(out_last2), .busy(busy2));

    // Pilots per lane and the hand-derived floor / half-up steps per lane.
    typedef struct {
        int a0; int b0; int a1; int b1;
        int fl0; int fl1; int rd0; int rd1;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int d, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d, expected %0d", name, d, act, exp);
        end
    endtask

    function automatic int satw(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int lane_val(input int d, input int l);
        logic signed [15:0] s16;
        logic signed [11:0] s12;
        if (d == 2) begin
            s12 = out_data2[l*12 +: 12];
            return int'(s12);
        end
        s16 = (d == 0) ? out_data0[l*16 +: 16] : out_data1[l*16 +: 16];
        return int'(s16);
    endfunction

    function automatic int expected(input vec_t v, input int d, input int l, input int k);
        int base;
        int step;
        base = (l == 0) ? v.a0 : v.a1;
        if (d == 1) step = (l == 0) ? v.rd0 : v.rd1;
        else        step = (l == 0) ? v.fl0 : v.fl1;
        return satw(base + k * step, (d == 2) ? 12 : 16);
    endfunction

    function automatic int get_valid(input int d);
        return (d == 0) ? int'(out_valid0) : (d == 1) ? int'(out_valid1) : int'(out_valid2);
    endfunction
    function automatic int get_ready(input int d);
        return (d == 0) ? int'(in_ready0) : (d == 1) ? int'(in_ready1) : int'(in_ready2);
    endfunction
    function automatic int get_idx(input int d);
        return (d == 0) ? int'(out_idx0) : (d == 1) ? int'(out_idx1) : int'(out_idx2);
    endfunction
    function automatic int get_last(input int d);
        return (d == 0) ? int'(out_last0) : (d == 1) ? int'(out_last1) : int'(out_last2);
    endfunction
    function automatic int get_busy(input int d);
        return (d == 0) ? int'(busy0) : (d == 1) ? int'(busy1) : int'(busy2);
    endfunction

    task automatic drive_pair(input vec_t v);
        pilot_a = {16'(v.a1), 16'(v.a0)};
        pilot_b = {16'(v.b1), 16'(v.b0)};
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_valid"}, d, get_valid(d), 0);
            chk({tag, "_busy"}, d, get_busy(d), 0);
        end
    endtask

    // Call at a negedge with the block idle. stall toggles out_ready 1,0,0,1;
    // hold keeps in_valid high with junk pilots during the burst.
    task automatic run_burst(input int vi, input bit stall, input bit hold);
        int k;
        int cyc;
        vec_t v;
        v = vecs[vi];
        drive_pair(v);
        in_valid = 1'b1;
        for (int d = 0; d < 3; d++) chk("in_ready_idle", d, get_ready(d), 1);
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            pilot_a = 32'h1234_5678;
            pilot_b = 32'h8765_4321;
        end else begin
            in_valid = 1'b0;
        end
        for (int d = 0; d < 3; d++) begin
            chk("calc_valid", d, get_valid(d), 0);
            chk("calc_busy", d, get_busy(d), 1);
            chk("calc_in_ready", d, get_ready(d), 0);
        end
        @(posedge clk);
        @(negedge clk);
        k = 0;
        cyc = 0;
        while (k < 8 && cyc < 100) begin
            out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (hold && k >= 6) in_valid = 1'b0;
            for (int d = 0; d < 3; d++) begin
                chk("emit_valid", d, get_valid(d), 1);
                chk("emit_idx", d, get_idx(d), k);
                chk("emit_last", d, get_last(d), (k == 7) ? 1 : 0);
                chk("emit_in_ready", d, get_ready(d), 0);
                chk("emit_lane0", d, lane_val(d, 0), expected(v, d, 0, k));
                chk("emit_lane1", d, lane_val(d, 1), expected(v, d, 1, k));
            end
            if (out_ready) k++;
            cyc++;
            @(posedge clk);
            @(negedge clk);
        end
        if (k < 8) chk("burst_timeout", 0, k, 8);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        check_idle_outputs("post_burst");
    endtask

    initial begin
        vecs[0] = '{a0: 100,    b0: 180,   a1: 0,     b1: -9,    fl0: 10,   fl1: -2,  rd0: 10,   rd1: -1};
        vecs[1] = '{a0: 2000,   b0: 2080,  a1: -2000, b1: -2080, fl0: 10,   fl1: -10, rd0: 10,   rd1: -10};
        vecs[2] = '{a0: 10,     b0: 50,    a1: -10,   b1: -50,   fl0: 5,    fl1: -5,  rd0: 5,    rd1: -5};
        vecs[3] = '{a0: 7,      b0: 7,     a1: -5,    b1: -5,    fl0: 0,    fl1: 0,   rd0: 0,    rd1: 0};
        vecs[4] = '{a0: -32768, b0: 32767, a1: 3,     b1: -4,    fl0: 8191, fl1: -1,  rd0: 8192, rd1: -1};

        #3;
        for (int d = 0; d < 3; d++) begin
            chk("reset_valid", d, get_valid(d), 0);
            chk("reset_in_ready", d, get_ready(d), 0);
            chk("reset_busy", d, get_busy(d), 0);
            chk("reset_idx", d, get_idx(d), 0);
            chk("reset_data", d, lane_val(d, 0), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_burst(i, 1'b0, 1'b0);
        end

        // Backpressure with in_valid held high while busy.
        run_burst(2, 1'b1, 1'b1);

        // Reset in the middle of a burst at idx 3.
        drive_pair(vecs[0]);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_reset_idx", 0, get_idx(0), 3);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("midrst_valid", d, get_valid(d), 0);
            chk("midrst_last", d, get_last(d), 0);
            chk("midrst_idx", d, get_idx(d), 0);
            chk("midrst_busy", d, get_busy(d), 0);
            chk("midrst_in_ready", d, get_ready(d), 0);
            chk("midrst_lane0", d, lane_val(d, 0), 0);
            chk("midrst_lane1", d, lane_val(d, 1), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk("post_rst_in_ready", d, get_ready(d), 1);
        @(negedge clk);
        run_burst(2, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
